// File: rtl/systolic_array_nxn_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : systolic_array_nxn_if                                            |
// | Brief   : Host-side operand stream and result readout bundle of the array. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface systolic_array_nxn_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_WIDTH    = 16
);
    localparam int IDX_W = $clog2(N);

    logic                    pause;
    logic                    start;
    logic [K_WIDTH-1:0]      k_len;
    logic                    accumulate;
    logic [N*DATA_WIDTH-1:0] a_in;
    logic [N*DATA_WIDTH-1:0] b_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [N*ACC_WIDTH-1:0]  res_data;
    logic [IDX_W-1:0]        res_idx;
    logic                    res_valid;
    logic                    res_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output pause, start, k_len, accumulate, a_in, b_in, in_valid, res_ready,
        input  in_ready, res_data, res_idx, res_valid, busy, done
    );

    modport slave (
        input  pause, start, k_len, accumulate, a_in, b_in, in_valid, res_ready,
        output in_ready, res_data, res_idx, res_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_array_nxn.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : systolic_array_nxn                                               |
// | Brief   : NxN output-stationary signed MAC array with skew and row readout.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module systolic_array_nxn #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_WIDTH    = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    systolic_array_nxn_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int FC_W  = $clog2(2 * N);
    localparam int PW    = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_FLUSH  = 3'd2,
        S_READ   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] k_len_q, k_len_d;
    logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [IDX_W-1:0]   row_q, row_d;

    logic w_run;
    logic w_accept;
    logic w_clear;

    assign w_run    = ~bus.pause;
    assign w_accept = (state_q == S_STREAM) && w_run && bus.in_valid;
    assign w_clear  = (state_q == S_IDLE) && w_run && bus.start && ~bus.accumulate;

    // Every next-state default is "hold", so pause freezes the controller for free.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        if (w_run) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        k_len_d     = bus.k_len;
                        beat_cnt_d  = '0;
                        flush_cnt_d = '0;
                        row_d       = '0;
                        state_d     = (bus.k_len == '0) ? S_READ : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (bus.in_valid) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (beat_cnt_q == k_len_q - 1'b1) begin
                            flush_cnt_d = '0;
                            state_d     = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FC_W'(2 * N - 2)) begin
                        state_d = S_READ;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (bus.res_ready) begin
                        if (row_q == IDX_W'(N - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
        end
    end

    assign bus.in_ready  = (state_q == S_STREAM) && w_run;
    assign bus.res_valid = (state_q == S_READ);
    assign bus.res_idx   = row_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE) && w_run;

    // Operand fabric: w_a/w_v flow right along rows, w_b flows down columns.
    logic signed [DATA_WIDTH-1:0] w_a   [N][N];
    logic                         w_v   [N][N];
    logic signed [DATA_WIDTH-1:0] w_b   [N][N];
    logic signed [ACC_WIDTH-1:0]  w_acc [N][N];

    // Row i / column j input skew: i+1 (j+1) stages, so beat t lands on PE(i,j) at t+1+i+j.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            logic [DATA_WIDTH-1:0] a_chain_q [0:gi];
            logic                  v_chain_q [0:gi];
            logic [DATA_WIDTH-1:0] b_chain_q [0:gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k <= gi; k++) begin
                        a_chain_q[k] <= '0;
                        v_chain_q[k] <= 1'b0;
                        b_chain_q[k] <= '0;
                    end
                end else if (w_run) begin
                    a_chain_q[0] <= bus.a_in[gi*DATA_WIDTH +: DATA_WIDTH];
                    v_chain_q[0] <= w_accept;
                    b_chain_q[0] <= bus.b_in[gi*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k <= gi; k++) begin
                        a_chain_q[k] <= a_chain_q[k-1];
                        v_chain_q[k] <= v_chain_q[k-1];
                        b_chain_q[k] <= b_chain_q[k-1];
                    end
                end
            end

            assign w_a[gi][0] = a_chain_q[gi];
            assign w_v[gi][0] = v_chain_q[gi];
            assign w_b[0][gi] = b_chain_q[gi];
        end

        for (gi = 0; gi < N; gi++) begin : g_pe_row
            for (gj = 0; gj < N; gj++) begin : g_pe_col
                logic signed [PW-1:0]        w_prod;
                logic signed [ACC_WIDTH-1:0] acc_q;

                assign w_prod = w_a[gi][gj] * w_b[gi][gj];

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        acc_q <= '0;
                    end else if (w_run) begin
                        if (w_clear) begin
                            acc_q <= '0;
                        end else if (w_v[gi][gj]) begin
                            acc_q <= acc_q + ACC_WIDTH'(w_prod);
                        end
                    end
                end
                assign w_acc[gi][gj] = acc_q;

                // Edge PEs have no downstream neighbour, so they carry no forwarding stage.
                if (gj < N - 1) begin : g_fwd_a
                    logic signed [DATA_WIDTH-1:0] a_q;
                    logic                         v_q;
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) begin
                            a_q <= '0;
                            v_q <= 1'b0;
                        end else if (w_run) begin
                            a_q <= w_a[gi][gj];
                            v_q <= w_v[gi][gj];
                        end
                    end
                    assign w_a[gi][gj+1] = a_q;
                    assign w_v[gi][gj+1] = v_q;
                end

                if (gi < N - 1) begin : g_fwd_b
                    logic signed [DATA_WIDTH-1:0] b_q;
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) begin
                            b_q <= '0;
                        end else if (w_run) begin
                            b_q <= w_b[gi][gj];
                        end
                    end
                    assign w_b[gi+1][gj] = b_q;
                end
            end
        end
    endgenerate

    logic [N*ACC_WIDTH-1:0] w_res_row;
    always_comb begin
        w_res_row = '0;
        for (int j = 0; j < N; j++) begin
            w_res_row[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[row_q][j];
        end
    end
    assign bus.res_data = w_res_row;

endmodule
`default_nettype wire
